uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter (`tx`) among `CANT_REQ` byte sources, for example the ALU result path, an echo path and a status/error reporter.
- Sits between the requesters and `tx`, driving its start/data inputs and consuming its done pulse.
- Grants requesters round-robin, one byte per grant.
- Guards each transmission with a watchdog so a stuck transmitter cannot hang the system.

---
 rtl/uart_tx_arbiter_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/uart_tx_arbiter_rr_priority_picker.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, parameter
// defaults and small helpers used by the arbiter and its picker.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_t;

    localparam int DEF_CANT_REQ       = 3;
    localparam int DEF_WIDTH_WORD     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 200000;
    localparam int DEF_CNT_W          = $clog2(DEF_TIMEOUT_CYCLES);

    localparam int GRANT_W = 2;
    localparam int ERR_W   = 8;

    // Error counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Request/transmitter/status bundle between the byte sources, the arbiter and tx.
interface uart_tx_arbiter_if
    import uart_tx_arbiter_pkg::*;
#(
    parameter int CANT_REQ   = DEF_CANT_REQ,
    parameter int WIDTH_WORD = DEF_WIDTH_WORD
);

    logic [CANT_REQ-1:0]            i_req_valid;
    logic [CANT_REQ*WIDTH_WORD-1:0] i_req_data;
    logic [CANT_REQ-1:0]            o_req_ready;
    logic                           o_tx_start;
    logic [WIDTH_WORD-1:0]          o_data_tx;
    logic                           i_tx_done;
    logic                           o_busy;
    logic [GRANT_W-1:0]             o_grant_id;
    logic                           o_timeout;
    logic [ERR_W-1:0]               o_err_count;

    modport master (
        input  i_req_valid, i_req_data, i_tx_done,
        output o_req_ready, o_tx_start, o_data_tx, o_busy,
               o_grant_id, o_timeout, o_err_count
    );

    modport slave (
        output i_req_valid, i_req_data, i_tx_done,
        input  o_req_ready, o_tx_start, o_data_tx, o_busy,
               o_grant_id, o_timeout, o_err_count
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: the first set request after last_grant,
// wrapping around, wins.
module rr_priority_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int CANT_REQ = DEF_CANT_REQ
) (
    input  logic [CANT_REQ-1:0] req,
    input  logic [GRANT_W-1:0]  last_grant,
    output logic                any,
    output logic [GRANT_W-1:0]  winner
);

    int idx;

    // Scan from the lowest priority to the highest so the closest hit wins.
    always_comb begin
        any    = |req;
        winner = '0;
        idx    = 0;
        for (int i = CANT_REQ; i >= 1; i--) begin
            idx = int'(last_grant) + i;
            if (idx >= CANT_REQ) idx = idx - CANT_REQ;
            if (req[idx]) winner = GRANT_W'(idx);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among CANT_REQ byte sources, one byte per
// round-robin grant, with a watchdog on every transmission.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int CANT_REQ       = DEF_CANT_REQ,
    parameter int WIDTH_WORD     = DEF_WIDTH_WORD,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                i_clock,
    input logic                i_reset,
    uart_tx_arbiter_if.master  bus
);

    localparam int                   CNT_W       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]     WD_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GRANT_W-1:0]   RESET_GRANT = GRANT_W'(CANT_REQ - 1);

    arb_state_t state, state_nxt;

    logic [GRANT_W-1:0]    last_grant;
    logic [CNT_W-1:0]      wd_cnt;
    logic [CNT_W-1:0]      wd_inc;
    logic                  pick_any;
    logic [GRANT_W-1:0]    pick_winner;
    logic                  load_grant;
    logic                  expire;
    logic [CANT_REQ-1:0]   ready_nxt;
    logic [WIDTH_WORD-1:0] win_data;

    logic [CANT_REQ-1:0]   req_ready_q;
    logic                  tx_start_q;
    logic [WIDTH_WORD-1:0] data_tx_q;
    logic                  busy_q;
    logic [GRANT_W-1:0]    grant_id_q;
    logic                  timeout_q;
    logic [ERR_W-1:0]      err_count_q;

    rr_priority_picker #(
        .CANT_REQ (CANT_REQ)
    ) u_picker (
        .req        (bus.i_req_valid),
        .last_grant (last_grant),
        .any        (pick_any),
        .winner     (pick_winner)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_grant = 1'b0;
        expire     = 1'b0;
        wd_inc     = wd_cnt + CNT_W'(1);
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt  = ST_LOAD;
                    load_grant = 1'b1;
                end
            end
            ST_LOAD:  state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A done pulse in the expiry cycle still counts as success.
                if (bus.i_tx_done) begin
                    state_nxt = ST_IDLE;
                end else if (wd_inc == WD_LAST) begin
                    state_nxt = ST_IDLE;
                    expire    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_nxt = '0;
        win_data  = '0;
        for (int k = 0; k < CANT_REQ; k++) begin
            if (pick_winner == GRANT_W'(k)) begin
                ready_nxt[k] = load_grant;
                win_data     = bus.i_req_data[k*WIDTH_WORD +: WIDTH_WORD];
            end
        end
    end

    // Every output is a register loaded from the next-state decision.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            last_grant  <= RESET_GRANT;
            wd_cnt      <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            data_tx_q   <= '0;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
            timeout_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            req_ready_q <= ready_nxt;
            tx_start_q  <= (state_nxt == ST_START);
            busy_q      <= (state_nxt != ST_IDLE);
            timeout_q   <= expire;
            if (load_grant) begin
                data_tx_q  <= win_data;
                grant_id_q <= pick_winner;
                last_grant <= pick_winner;
            end
            if (state == ST_START)     wd_cnt <= '0;
            else if (state == ST_WAIT) wd_cnt <= wd_inc;
            if (expire) err_count_q <= sat_inc_err(err_count_q);
        end
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_data_tx   = data_tx_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_grant_id  = grant_id_q;
    assign bus.o_timeout   = timeout_q;
    assign bus.o_err_count = err_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short watchdog (50 clocks).
module tb_uart_tx_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 8;
    localparam int TO   = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    uart_tx_arbiter_if #(.CANT_REQ(NREQ), .WIDTH_WORD(W)) bus ();

    uart_tx_arbiter #(
        .CANT_REQ       (NREQ),
        .WIDTH_WORD     (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"}, bus.o_req_ready, 0);
        check({tag, "_start"}, bus.o_tx_start, 0);
        check({tag, "_data"},  bus.o_data_tx, 0);
        check({tag, "_busy"},  bus.o_busy, 0);
        check({tag, "_grant"}, bus.o_grant_id, 0);
        check({tag, "_tmo"},   bus.o_timeout, 0);
        check({tag, "_err"},   bus.o_err_count, 0);
    endtask

    task automatic pulse_done();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    // Leaves the bench in the cycle where o_tx_start is high.
    task automatic wait_start(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            if (bus.o_tx_start) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) check({tag, "_start_seen"}, 0, 1);
    endtask

    int s_prev, s_now, t_at, n_tmo;
    logic [7:0] exp_bytes [4];

    initial begin
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        bus.i_tx_done   = 1'b0;
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22;
        exp_bytes[2] = 8'h33; exp_bytes[3] = 8'h11;

        // Reset state
        tick();
        check_idle_zero("rst");
        tick();
        rst = 1'b0;

        // 1: single request on requester 1
        bus.i_req_data  = {8'h00, 8'hA5, 8'h00};
        bus.i_req_valid = 3'b010;
        tick();
        check("t1_ready", bus.o_req_ready, 3'b010);
        check("t1_busy",  bus.o_busy, 1);
        check("t1_grant", bus.o_grant_id, 1);
        check("t1_start_early", bus.o_tx_start, 0);
        bus.i_req_valid = '0;
        tick();
        check("t1_start", bus.o_tx_start, 1);
        check("t1_data",  bus.o_data_tx, 8'hA5);
        check("t1_ready_drop", bus.o_req_ready, 0);
        tick();
        check("t1_start_once", bus.o_tx_start, 0);
        pulse_done();
        check("t1_idle", bus.o_busy, 0);
        check("t1_data_hold", bus.o_data_tx, 8'hA5);

        // 2: fairness with all three requesting
        do_reset();
        bus.i_req_data  = {8'h33, 8'h22, 8'h11};
        bus.i_req_valid = 3'b111;
        s_prev = 0;
        for (int b = 0; b < 4; b++) begin
            wait_start("t2", s_now);
            check($sformatf("t2_byte%0d", b), bus.o_data_tx, exp_bytes[b]);
            check($sformatf("t2_grant%0d", b), bus.o_grant_id, b % NREQ);
            if (b > 0) check($sformatf("t2_gap%0d", b), s_now - s_prev, 23);
            s_prev = s_now;
            if (b == 3) bus.i_req_valid = '0;
            for (int i = 0; i < 20; i++) tick();
            pulse_done();
        end
        check("t2_idle", bus.o_busy, 0);

        // 3: watchdog expiry, then a normal grant
        do_reset();
        bus.i_req_data  = {8'h00, 8'h77, 8'h5A};
        bus.i_req_valid = 3'b001;
        wait_start("t3", s_now);
        bus.i_req_valid = '0;
        t_at = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.o_timeout) begin
                t_at = cyc;
                break;
            end
        end
        check("t3_tmo_delay", t_at - s_now, TO);
        check("t3_err", bus.o_err_count, 1);
        check("t3_idle", bus.o_busy, 0);
        tick();
        check("t3_tmo_pulse", bus.o_timeout, 0);
        bus.i_req_valid = 3'b010;
        wait_start("t3b", s_now);
        bus.i_req_valid = '0;
        check("t3_next_data", bus.o_data_tx, 8'h77);
        check("t3_next_grant", bus.o_grant_id, 1);
        tick();
        pulse_done();
        check("t3_next_idle", bus.o_busy, 0);

        // 4a: done in the expiry cycle wins over the timeout
        bus.i_req_valid = 3'b001;
        wait_start("t4", s_now);
        bus.i_req_valid = '0;
        for (int i = 0; i < TO - 1; i++) tick();
        check("t4_still_wait", bus.o_busy, 1);
        pulse_done();
        n_tmo = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.o_timeout) n_tmo++;
            tick();
        end
        check("t4_no_tmo", n_tmo, 0);
        check("t4_err_same", bus.o_err_count, 1);
        check("t4_idle", bus.o_busy, 0);

        // 4b: stray done in IDLE and in START is ignored
        pulse_done();
        check("t4_idle_done", bus.o_busy, 0);
        bus.i_req_data  = {8'h3C, 8'h00, 8'h00};
        bus.i_req_valid = 3'b100;
        tick();
        bus.i_req_valid = '0;
        check("t4_grant", bus.o_grant_id, 2);
        tick();
        check("t4_start", bus.o_tx_start, 1);
        check("t4_data", bus.o_data_tx, 8'h3C);
        pulse_done();
        check("t4_wait_after_stray", bus.o_busy, 1);
        tick();
        check("t4_wait_hold", bus.o_busy, 1);
        pulse_done();
        check("t4_done_idle", bus.o_busy, 0);

        // 5: reset in the middle of WAIT
        bus.i_req_data  = {8'h33, 8'h22, 8'h11};
        bus.i_req_valid = 3'b010;
        wait_start("t5", s_now);
        tick();
        tick();
        rst = 1'b1;
        bus.i_req_valid = 3'b111;
        tick();
        check_idle_zero("t5");
        rst = 1'b0;
        tick();
        check("t5_grant", bus.o_grant_id, 0);
        check("t5_ready", bus.o_req_ready, 3'b001);
        bus.i_req_valid = '0;
        tick();
        tick();
        pulse_done();

        // 6: error counter saturation
        do_reset();
        bus.i_req_valid = 3'b001;
        n_tmo = 0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (bus.o_timeout) begin
                n_tmo++;
                if (n_tmo == 100) check("t6_err100", bus.o_err_count, 100);
                if (n_tmo == 255) check("t6_err255", bus.o_err_count, 255);
                if (n_tmo == 300) break;
            end
        end
        check("t6_count", n_tmo, 300);
        check("t6_sat", bus.o_err_count, 255);
        bus.i_req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
